// File: rtl/circ_shift_reg_param.sv
// Parametrised load/rotate/shift register with a start/busy/done multi-step shift engine.
// Optional registered parity output enabled by defining CIRC_SHIFT_PARITY_EN.
module circ_shift_reg_param #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_in,
    input  logic             load,
    input  logic             start,
    input  logic [CW-1:0]    amount,
    input  logic             dir,
    input  logic             mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             shift_out,
    output logic             busy,
    output logic             done,
    output logic             parity_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    count;
    logic             dir_q;
    logic             mode_q;

    // One single-bit step; right = toward LSB, logical = fill from serial input.
    function automatic logic [WIDTH-1:0] step(
        input logic [WIDTH-1:0] value,
        input logic             right,
        input logic             logical,
        input logic             fill
    );
        logic ins;
        if (right) begin
            ins = logical ? fill : value[0];
            return {ins, value[WIDTH-1:1]};
        end else begin
            ins = logical ? fill : value[WIDTH-1];
            return {value[WIDTH-2:0], ins};
        end
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            data_q <= '0;
            count  <= '0;
            dir_q  <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        data_q <= load_in;
                    end else if (start) begin
                        dir_q  <= dir;
                        mode_q <= mode;
                        count  <= amount;
                        state  <= (amount == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data_q <= step(data_q, dir_q, mode_q, serial_in);
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign shift_out = dir_q ? data_q[0] : data_q[WIDTH-1];

`ifdef CIRC_SHIFT_PARITY_EN
    logic parity_q;

    // Tracks D one cycle late; re-registering when D holds leaves it unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_q;
        end
    end

    assign parity_out = parity_q;
`else
    assign parity_out = 1'b0;
`endif

endmodule

// File: doc/circ_shift_reg_param.md
Name: circ_shift_reg_param

Overview:
- Parametrised successor to the team's fixed 16-bit load/rotate register.
- WIDTH-bit register with parallel load and a multi-step shift engine. Direction is left or right; mode is rotate or logical shift with serial fill.
- A start/busy/done handshake runs a programmed number of single-bit steps.
- Sits between a parallel data source and a serial consumer (serialiser / bit-rotator in lab datapaths).

Parameters:
- WIDTH, 16, register width in bits (>= 2).
- CW, $clog2(WIDTH)+1, width of the amount port; must hold the value WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- load_in  input  WIDTH  parallel load data.
- load  input  1  parallel load request; honoured only in IDLE.
- start  input  1  begin a shift sequence; honoured only in IDLE.
- amount  input  CW  number of single-bit steps; sampled with start.
- dir  input  1  0 = left (toward MSB), 1 = right (toward LSB); sampled with start.
- mode  input  1  0 = rotate, 1 = logical shift with serial_in fill; sampled with start.
- serial_in  input  1  fill bit for logical shift; sampled live every step.
- data_out  output  WIDTH  current register contents.
- shift_out  output  1  bit that the next step ejects: D[WIDTH-1] if latched dir = 0, D[0] if latched dir = 1.
- busy  output  1  high while steps are executing.
- done  output  1  one-cycle pulse when a sequence completes.
- parity_out  output  1  see Optional Feature.

Behaviour:
- Reset (async, immediate):
  - D = 0, state = IDLE, counter = 0, latched dir/mode = 0.
  - busy = 0, done = 0, shift_out = 0, parity_out = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load = 1: D <= load_in on the edge, stay IDLE. load beats start when both are high; start is dropped.
  - start = 1, load = 0: latch dir, mode and amount.
    - amount > 0: counter <= amount, next state SHIFT.
    - amount = 0: next state DONE, D unchanged.
  - Neither asserted: D holds.
- SHIFT:
  - busy = 1. Each edge performs exactly one step and decrements counter.
  - When counter = 1 on a step, next state is DONE.
  - A sequence of amount N occupies exactly N SHIFT cycles.
- Step definitions:
  - Left rotate: D <= {D[WIDTH-2:0], D[WIDTH-1]}.
  - Right rotate: D <= {D[0], D[WIDTH-1:1]}.
  - Left logical: D <= {D[WIDTH-2:0], serial_in}.
  - Right logical: D <= {serial_in, D[WIDTH-1:1]}.
- DONE:
  - done = 1 and busy = 0 for exactly one cycle; next state IDLE. D holds.
  - load and start are ignored in DONE.
- load and start are ignored while busy; no queuing.
- amount may exceed WIDTH (up to 2^CW-1). Steps run exactly amount times: a rotate wraps modulo WIDTH, a logical shift fully flushes to serial_in.
- Latency: start to done is N+1 cycles for amount N; amount 0 gives done on the cycle after start.
- Reset asserted mid-sequence aborts immediately. There is no done pulse; the block returns to IDLE with D = 0.
- data_out is a register output. shift_out and busy are decoded from registered state.

Optional Feature:
- Macro: CIRC_SHIFT_PARITY_EN.
- Defined: parity_out is the registered XOR-reduction of D, updated on every edge where D changes, so it follows D with one cycle of lag. parity_out resets to 0.
- Undefined: the parity_out port remains present, tied to 0, and no parity logic is built.

Test Plan:
- WIDTH=16; load 0x8001; start amount=1, dir=0, mode=0 -> data_out=0x0003 after 1 busy cycle; done pulses at the next cycle.
- Load 0x0001; start amount=4, dir=1, mode=0 -> busy high 4 cycles, data_out=0x1000; shift_out sequence 1,0,0,0 before each step.
- Load 0xF0F0; start amount=4, dir=0, mode=1, serial_in=1 -> data_out=0x0F0F.
- Load 0xABCD; start amount=0 -> busy never rises, done pulses 1 cycle after start, data_out=0xABCD. With amount=16, rotate -> data_out=0xABCD after 16 busy cycles.
- Raise load=1 with load_in=0x1234 during busy -> ignored, final result unaffected. Raise load and start together in IDLE -> load wins, busy stays 0.
- Assert reset at the 3rd busy cycle -> data_out=0, busy=0 immediately, no done pulse. With CIRC_SHIFT_PARITY_EN defined: load 0x0007 -> parity_out=1 on the next cycle.
